// File: rtl/passcode_checker.sv
// Passcode responder: collects DIGITS nibbles on Enter presses, compares them with
// PASSCODE, reports pass/fail and enforces a timed lockout after repeated failures.
module passcode_checker #(
  parameter int                  DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] PASSCODE    = 16'h1234,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  LOCK_CYCLES = 500
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       EnablePasscode,
  input  logic       EnterButton,
  input  logic [3:0] Digit_In,
  output logic [1:0] Pass_Fail,
  output logic [3:0] Digit_Count,
  output logic       Locked,
  output logic [3:0] Tries_Left
);

  localparam int SW = 4 * DIGITS;
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, PASS, FAIL, LOCK} state_t;

  state_t          state;
  logic [SW-1:0]   shift;
  logic [3:0]      fail_cnt;
  logic [LW-1:0]   lock_cnt;
  logic            enter_prev;
  logic            enter_rise;
  logic [3:0]      fail_next;

  assign enter_rise = EnterButton & ~enter_prev;
  assign fail_next  = fail_cnt + 4'd1;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      shift       <= '0;
      fail_cnt    <= '0;
      lock_cnt    <= '0;
      enter_prev  <= 1'b0;
      Pass_Fail   <= 2'b00;
      Digit_Count <= 4'd0;
      Locked      <= 1'b0;
      Tries_Left  <= 4'(MAX_TRIES);
    end else begin
      enter_prev <= EnterButton;

      // Status outputs are a registered decode of the state, so a verdict appears
      // two edges after the last digit and Locked spans exactly the LOCK residency.
      case (state)
        PASS:       Pass_Fail <= 2'b01;
        FAIL, LOCK: Pass_Fail <= 2'b10;
        default:    Pass_Fail <= 2'b00;
      endcase
      Locked <= (state == LOCK);

      case (state)
        IDLE: begin
          if (EnablePasscode) begin
            state       <= COLLECT;
            shift       <= '0;
            Digit_Count <= 4'd0;
          end
        end
        COLLECT: begin
          if (!EnablePasscode) begin
            state       <= IDLE;
            Digit_Count <= 4'd0;
          end else if (enter_rise) begin
            shift       <= SW'({shift, Digit_In});
            Digit_Count <= Digit_Count + 4'd1;
            if (Digit_Count == 4'(DIGITS - 1)) state <= CHECK;
          end
        end
        CHECK: begin
          if (!EnablePasscode) begin
            state       <= IDLE;
            Digit_Count <= 4'd0;
          end else if (shift == PASSCODE) begin
            state      <= PASS;
            fail_cnt   <= 4'd0;
            Tries_Left <= 4'(MAX_TRIES);
          end else begin
            fail_cnt   <= fail_next;
            Tries_Left <= 4'(MAX_TRIES) - fail_next;
            if (fail_next == 4'(MAX_TRIES)) begin
              state       <= LOCK;
              lock_cnt    <= LW'(LOCK_CYCLES - 1);
              Digit_Count <= 4'd0;
            end else begin
              state <= FAIL;
            end
          end
        end
        PASS: begin
          if (!EnablePasscode) begin
            state       <= IDLE;
            Digit_Count <= 4'd0;
          end
        end
        FAIL: begin
          // The press that clears a failure only restarts entry; its digit is dropped.
          if (!EnablePasscode) begin
            state       <= IDLE;
            Digit_Count <= 4'd0;
          end else if (enter_rise) begin
            state       <= COLLECT;
            shift       <= '0;
            Digit_Count <= 4'd0;
          end
        end
        LOCK: begin
          // Abort is deferred until the lock expires so it cannot shorten the penalty.
          if (lock_cnt == '0) begin
            state       <= EnablePasscode ? COLLECT : IDLE;
            fail_cnt    <= 4'd0;
            Tries_Left  <= 4'(MAX_TRIES);
            shift       <= '0;
            Digit_Count <= 4'd0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_passcode_checker.sv
// Bench for passcode_checker: directed scenarios plus randomized entries checked
// against an entry-level model (code equality and a consecutive-failure count).
module tb_passcode_checker;

  localparam logic [15:0] CODE      = 16'h1234;
  localparam int          MAX_TRIES = 3;
  localparam int          LOCK_CYC  = 500;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       EnablePasscode = 1'b0;
  logic       EnterButton = 1'b0;
  logic [3:0] Digit_In = 4'd0;
  logic [1:0] Pass_Fail;
  logic [3:0] Digit_Count;
  logic       Locked;
  logic [3:0] Tries_Left;

  int tests  = 0;
  int errors = 0;

  passcode_checker #(
    .DIGITS(4), .PASSCODE(CODE), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYC)
  ) dut (
    .Clk(Clk), .Rst(Rst), .EnablePasscode(EnablePasscode), .EnterButton(EnterButton),
    .Digit_In(Digit_In), .Pass_Fail(Pass_Fail), .Digit_Count(Digit_Count),
    .Locked(Locked), .Tries_Left(Tries_Left)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Rst = 1'b0; EnablePasscode = 1'b0; EnterButton = 1'b0; Digit_In = 4'd0;
    repeat (2) tick();
    Rst = 1'b1;
    tick();
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    Digit_In = d;
    EnterButton = 1'b1;
    repeat (hold) tick();
    EnterButton = 1'b0;
    tick();
  endtask

  task automatic enter_code(input logic [15:0] c, input int hold);
    for (int k = 3; k >= 0; k--) begin
      logic [15:0] v;
      v = c >> (4 * k);
      press(v[3:0], hold);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (Pass_Fail !== 2'b00) begin errors++; $display("FAIL reset_pf: got %b want 00", Pass_Fail); end
    tests++; if (Digit_Count !== 4'd0) begin errors++; $display("FAIL reset_dc: got %0d want 0", Digit_Count); end
    tests++; if (Locked !== 1'b0) begin errors++; $display("FAIL reset_lk: got %b want 0", Locked); end
    tests++; if (Tries_Left !== 4'(MAX_TRIES)) begin errors++; $display("FAIL reset_tl: got %0d want %0d", Tries_Left, MAX_TRIES); end
  endtask

  task automatic test_correct_entry();
    apply_reset();
    EnablePasscode = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      press(4'(k), 5);
      tests++; if (Digit_Count !== 4'(k)) begin errors++; $display("FAIL t1_count%0d: got %0d want %0d", k, Digit_Count, k); end
    end
    Digit_In = 4'd4; EnterButton = 1'b1;
    tick();
    tests++; if (Digit_Count !== 4'd4) begin errors++; $display("FAIL t1_count4: got %0d want 4", Digit_Count); end
    tests++; if (Pass_Fail !== 2'b00) begin errors++; $display("FAIL t1_pf_e0: got %b want 00", Pass_Fail); end
    tick();
    tests++; if (Pass_Fail !== 2'b00) begin errors++; $display("FAIL t1_pf_e1: got %b want 00", Pass_Fail); end
    tick();
    tests++; if (Pass_Fail !== 2'b01) begin errors++; $display("FAIL t1_pf_e2: got %b want 01", Pass_Fail); end
    tests++; if (Tries_Left !== 4'd3) begin errors++; $display("FAIL t1_tries: got %0d want 3", Tries_Left); end
    repeat (2) tick();
    EnterButton = 1'b0;
    press(4'd9, 3);
    tests++; if (Pass_Fail !== 2'b01) begin errors++; $display("FAIL t1_pass_hold: got %b want 01", Pass_Fail); end
  endtask

  task automatic test_wrong_then_right();
    apply_reset();
    EnablePasscode = 1'b1;
    tick();
    enter_code(16'h1235, 5);
    tests++; if (Pass_Fail !== 2'b10) begin errors++; $display("FAIL t2_pf_fail: got %b want 10", Pass_Fail); end
    tests++; if (Tries_Left !== 4'd2) begin errors++; $display("FAIL t2_tries2: got %0d want 2", Tries_Left); end
    press(4'd1, 5);
    tests++; if (Pass_Fail !== 2'b00) begin errors++; $display("FAIL t2_pf_clear: got %b want 00", Pass_Fail); end
    tests++; if (Digit_Count !== 4'd0) begin errors++; $display("FAIL t2_dc_clear: got %0d want 0", Digit_Count); end
    enter_code(CODE, 5);
    tests++; if (Pass_Fail !== 2'b01) begin errors++; $display("FAIL t2_pf_pass: got %b want 01", Pass_Fail); end
    tests++; if (Tries_Left !== 4'd3) begin errors++; $display("FAIL t2_tries3: got %0d want 3", Tries_Left); end
  endtask

  task automatic test_lockout();
    int lk, pf;
    apply_reset();
    EnablePasscode = 1'b1;
    tick();
    for (int n = 0; n < 2; n++) begin
      enter_code(16'h0000, 5);
      press(4'd0, 2);
    end
    for (int k = 0; k < 3; k++) press(4'd0, 5);
    Digit_In = 4'd0; EnterButton = 1'b1;
    tick();
    lk = 0; pf = 0;
    for (int i = 0; i < 700; i++) begin
      if (i == 0) EnterButton = 1'b0;
      if (i == 50) begin EnterButton = 1'b1; Digit_In = 4'd5; end
      if (i == 53) EnterButton = 1'b0;
      tick();
      if (Locked) lk++;
      if (Pass_Fail == 2'b10) pf++;
      if (i == 60) begin
        tests++; if (Digit_Count !== 4'd0) begin errors++; $display("FAIL t3_dc_in_lock: got %0d want 0", Digit_Count); end
        tests++; if (Tries_Left !== 4'd0) begin errors++; $display("FAIL t3_tries_in_lock: got %0d want 0", Tries_Left); end
      end
    end
    tests++; if (lk != LOCK_CYC) begin errors++; $display("FAIL t3_lock_len: got %0d want %0d", lk, LOCK_CYC); end
    tests++; if (pf != LOCK_CYC) begin errors++; $display("FAIL t3_pf_len: got %0d want %0d", pf, LOCK_CYC); end
    tests++; if (Locked !== 1'b0) begin errors++; $display("FAIL t3_unlocked: got %b want 0", Locked); end
    tests++; if (Tries_Left !== 4'd3) begin errors++; $display("FAIL t3_tries_after: got %0d want 3", Tries_Left); end
    enter_code(CODE, 3);
    tests++; if (Pass_Fail !== 2'b01) begin errors++; $display("FAIL t3_collect_after: got %b want 01", Pass_Fail); end
  endtask

  task automatic test_held_button();
    apply_reset();
    EnablePasscode = 1'b1;
    tick();
    press(4'd7, 20);
    tests++; if (Digit_Count !== 4'd1) begin errors++; $display("FAIL t4_one_capture: got %0d want 1", Digit_Count); end
  endtask

  task automatic test_abort_keeps_tries();
    apply_reset();
    EnablePasscode = 1'b1;
    tick();
    enter_code(16'h0000, 2);
    press(4'd0, 2);
    enter_code(16'h0000, 2);
    EnablePasscode = 1'b0;
    repeat (2) tick();
    EnablePasscode = 1'b1;
    tick();
    tests++; if (Pass_Fail !== 2'b00) begin errors++; $display("FAIL t5_pf: got %b want 00", Pass_Fail); end
    tests++; if (Tries_Left !== 4'd1) begin errors++; $display("FAIL t5_tries: got %0d want 1", Tries_Left); end
    enter_code(16'h0000, 2);
    tests++; if (Locked !== 1'b1) begin errors++; $display("FAIL t5_locked: got %b want 1", Locked); end
    // Aborting during lock must not release it early.
    EnablePasscode = 1'b0;
    repeat (10) tick();
    tests++; if (Locked !== 1'b1) begin errors++; $display("FAIL t5_abort_in_lock: got %b want 1", Locked); end
    repeat (LOCK_CYC) tick();
    tests++; if (Locked !== 1'b0 || Pass_Fail !== 2'b00) begin errors++; $display("FAIL t5_lock_to_idle: got lk=%b pf=%b want lk=0 pf=00", Locked, Pass_Fail); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    EnablePasscode = 1'b1;
    tick();
    press(4'd1, 2);
    press(4'd2, 2);
    tests++; if (Digit_Count !== 4'd2) begin errors++; $display("FAIL t6_pre_dc: got %0d want 2", Digit_Count); end
    #2 Rst = 1'b0;
    #1;
    tests++; if (Digit_Count !== 4'd0) begin errors++; $display("FAIL t6_dc_async: got %0d want 0", Digit_Count); end
    tests++; if (Pass_Fail !== 2'b00) begin errors++; $display("FAIL t6_pf_async: got %b want 00", Pass_Fail); end
    apply_reset();
    EnablePasscode = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) begin
      enter_code(16'h9999, 2);
      if (n < 2) press(4'd0, 2);
    end
    tests++; if (Locked !== 1'b1) begin errors++; $display("FAIL t6_pre_lock: got %b want 1", Locked); end
    #2 Rst = 1'b0;
    #1;
    tests++; if (Locked !== 1'b0) begin errors++; $display("FAIL t6_lk_async: got %b want 0", Locked); end
    tests++; if (Pass_Fail !== 2'b00) begin errors++; $display("FAIL t6_pf_lock_async: got %b want 00", Pass_Fail); end
    tests++; if (Tries_Left !== 4'(MAX_TRIES)) begin errors++; $display("FAIL t6_tl_async: got %0d want %0d", Tries_Left, MAX_TRIES); end
    tests++; if (Digit_Count !== 4'd0) begin errors++; $display("FAIL t6_dc_lock_async: got %0d want 0", Digit_Count); end
  endtask

  task automatic test_random();
    int fails, kind, nd;
    logic [15:0] c;
    logic [1:0]  exp_pf;
    logic        exp_lk;
    apply_reset();
    EnablePasscode = 1'b1;
    tick();
    fails = 0;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 3) begin
        nd = int'($urandom_range(0, 3));
        for (int k = 0; k < nd; k++) press(4'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
        tests++; if (Digit_Count !== 4'(nd)) begin errors++; $display("FAIL rnd_partial_dc[%0d]: got %0d want %0d", n, Digit_Count, nd); end
        EnablePasscode = 1'b0;
        repeat (2) tick();
        tests++; if (Digit_Count !== 4'd0 || Pass_Fail !== 2'b00 || Tries_Left !== 4'(MAX_TRIES - fails)) begin
          errors++; $display("FAIL rnd_abort[%0d]: got dc=%0d pf=%b tl=%0d want dc=0 pf=00 tl=%0d", n, Digit_Count, Pass_Fail, Tries_Left, MAX_TRIES - fails);
        end
        EnablePasscode = 1'b1;
        tick();
      end else begin
        c = (kind == 0) ? CODE : 16'($urandom);
        if (kind != 0 && c == CODE) c = c ^ 16'h0001;
        enter_code(c, int'($urandom_range(1, 4)));
        repeat (2) tick();
        if (c == CODE) fails = 0;
        else fails++;
        exp_lk = (fails == MAX_TRIES);
        exp_pf = (c == CODE) ? 2'b01 : 2'b10;
        tests++; if (Pass_Fail !== exp_pf || Locked !== exp_lk || Tries_Left !== 4'(MAX_TRIES - fails)) begin
          errors++; $display("FAIL rnd_entry[%0d] code=%h: got pf=%b lk=%b tl=%0d want pf=%b lk=%b tl=%0d", n, c, Pass_Fail, Locked, Tries_Left, exp_pf, exp_lk, MAX_TRIES - fails);
        end
        if (c == CODE) begin
          EnablePasscode = 1'b0;
          repeat (2) tick();
          EnablePasscode = 1'b1;
          tick();
        end else if (exp_lk) begin
          repeat (LOCK_CYC + 2) tick();
          fails = 0;
          tests++; if (Locked !== 1'b0 || Tries_Left !== 4'(MAX_TRIES)) begin
            errors++; $display("FAIL rnd_unlock[%0d]: got lk=%b tl=%0d want lk=0 tl=%0d", n, Locked, Tries_Left, MAX_TRIES);
          end
        end else begin
          press(4'($urandom_range(0, 15)), int'($urandom_range(1, 3)));
          tests++; if (Digit_Count !== 4'd0 || Pass_Fail !== 2'b00) begin
            errors++; $display("FAIL rnd_clear[%0d]: got dc=%0d pf=%b want dc=0 pf=00", n, Digit_Count, Pass_Fail);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct_entry();
    test_wrong_then_right();
    test_lockout();
    test_held_button();
    test_abort_keeps_tries();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
